// File: rtl/muldiv_sched.sv
// muldiv_sched: E-stage sequencer that starts the iterative multiplier/divider, stalls until done,
// and commits exactly one HI/LO write (plain, MADD/MSUB accumulate, or MTHI/MTLO) per instruction.
module muldiv_sched #(
   parameter int DW   = 32,
   parameter int OP_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   input  logic [OP_W-1:0] op_i,
   input  logic [DW-1:0]   src_a_i,
   input  logic [DW-1:0]   src_b_i,
   input  logic            pipe_stall_i,
   input  logic            flush_i,
   input  logic            excp_i,
   output logic            mul_start_o,
   output logic            mul_sign_o,
   input  logic            mul_ready_i,
   input  logic [2*DW-1:0] mul_res_i,
   output logic            div_start_o,
   output logic            div_sign_o,
   input  logic            div_ready_i,
   input  logic [2*DW-1:0] div_res_i,
   output logic            unit_flush_o,
   input  logic [2*DW-1:0] hilo_rdata_i,
   output logic            hilo_we_o,
   output logic [1:0]      hilo_sel_o,
   output logic [2*DW-1:0] hilo_wdata_o,
   output logic            stall_o,
   output logic [DW-1:0]   mul_lo_o
);
   typedef enum logic [1:0] {IDLE, MBUSY, DBUSY, DONE} state_t;
   localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
   localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_MADD  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_MADDU = OP_W'(6);
   localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(8);
   localparam logic [OP_W-1:0] OP_MUL   = OP_W'(9);
   localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(11);
   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [2*DW-1:0] res_q, res_d;
   logic            is_mul, is_div, is_sgn, unit_rdy;
   logic [2*DW-1:0] unit_res, acc;
   assign is_mul   = op_i inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL};
   assign is_div   = op_i inside {OP_DIV, OP_DIVU};
   assign is_sgn   = op_i inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB, OP_MUL};
   assign unit_rdy = state_q == MBUSY ? mul_ready_i : div_ready_i;
   assign unit_res = state_q == MBUSY ? mul_res_i : div_res_i;
   // HI/LO is read at the commit cycle so an accumulate sees the latest architectural value
   assign acc = op_q inside {OP_MADD, OP_MADDU} ? hilo_rdata_i + res_q :
                op_q inside {OP_MSUB, OP_MSUBU} ? hilo_rdata_i - res_q : res_q;
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      res_d        = res_q;
      mul_start_o  = 1'b0;
      mul_sign_o   = 1'b0;
      div_start_o  = 1'b0;
      div_sign_o   = 1'b0;
      unit_flush_o = 1'b0;
      hilo_we_o    = 1'b0;
      hilo_sel_o   = 2'b00;
      hilo_wdata_o = '0;
      stall_o      = 1'b0;
      mul_lo_o     = '0;
      case (state_q)
         IDLE: if (rst && req_valid_i && !flush_i) begin
            if (op_i == OP_MTHI || op_i == OP_MTLO) begin
               hilo_we_o    = ~excp_i & ~pipe_stall_i;
               hilo_sel_o   = op_i == OP_MTHI ? 2'b11 : 2'b10;
               hilo_wdata_o = op_i == OP_MTHI ? {src_a_i, {DW{1'b0}}} : {{DW{1'b0}}, src_a_i};
            end else if (is_mul || is_div) begin
               mul_start_o = is_mul;
               mul_sign_o  = is_mul & is_sgn;
               div_start_o = is_div;
               div_sign_o  = is_div & is_sgn;
               op_d        = op_i;
               state_d     = is_mul ? MBUSY : DBUSY;
               stall_o     = 1'b1;
            end
         end
         MBUSY, DBUSY: begin
            unit_flush_o = flush_i;
            stall_o      = ~flush_i;
            if (flush_i) state_d = IDLE;
            else if (unit_rdy) begin
               res_d   = unit_res;
               state_d = DONE;
            end
         end
         DONE: begin
            mul_lo_o = res_q[DW-1:0];
            if (flush_i) state_d = IDLE;
            else if (!pipe_stall_i) begin
               hilo_we_o    = ~excp_i & (op_q != OP_MUL);
               hilo_wdata_o = acc;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end
endmodule
